// File: rtl/inst_dec_pkg.sv
// Shared RV32 decode constants: opcodes, ID/EX control-bit positions and immediate formats.
package inst_dec_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int CTRL_W       = 6;
    localparam int CTRL_REG_WR  = 5;
    localparam int CTRL_MEM_RD  = 4;
    localparam int CTRL_MEM_WR  = 3;
    localparam int CTRL_BRANCH  = 2;
    localparam int CTRL_JUMP    = 1;
    localparam int CTRL_ALU_SRC = 0;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

endpackage

// File: rtl/inst_dec_pipe_reg_file.sv
// 2R1W register file, x0 hard-wired to zero.
// INST_DEC_WB_BYPASS_EN: same-cycle write-back data is forwarded to the read ports.
module reg_file #(
    parameter int WORD_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [REG_ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]     wr_data,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr1,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr2,
    output logic [WORD_SIZE-1:0]     rd_data1,
    output logic [WORD_SIZE-1:0]     rd_data2
);

    localparam int DEPTH = 2 ** REG_ADDR_SIZE;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
`ifdef INST_DEC_WB_BYPASS_EN
        if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr2)) rd_data2 = wr_data;
`endif
    end

endmodule

// File: rtl/inst_dec_pipe.sv
// RISC-V ID stage: decode, immediate generation, load-use hazard and the ID/EX register.
// Optional INST_DEC_WB_BYPASS_EN enables write-through in the register file.
module inst_dec_pipe
    import inst_dec_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int PC_SIZE       = 64,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_if_id_valid,
    input  logic [PC_SIZE-1:0]       i_if_id_pc,
    input  logic [WORD_SIZE-1:0]     i_if_id_inst,
    output logic                     o_if_id_stall,
    input  logic                     i_ex_hold,
    input  logic                     i_flush,
    input  logic                     i_reg_wr,
    input  logic [REG_ADDR_SIZE-1:0] i_wr_reg,
    input  logic [WORD_SIZE-1:0]     i_wr_data,
    output logic                     o_id_ex_valid,
    output logic [PC_SIZE-1:0]       o_id_ex_pc,
    output logic [WORD_SIZE-1:0]     o_id_ex_rd1,
    output logic [WORD_SIZE-1:0]     o_id_ex_rd2,
    output logic [PC_SIZE-1:0]       o_id_ex_imm,
    output logic [REG_ADDR_SIZE-1:0] o_id_ex_rs1,
    output logic [REG_ADDR_SIZE-1:0] o_id_ex_rs2,
    output logic [REG_ADDR_SIZE-1:0] o_id_ex_rd,
    output logic [3:0]               o_id_ex_alu_op,
    output logic [CTRL_W-1:0]        o_id_ex_ctrl
);

    function automatic logic signed [PC_SIZE-1:0] imm_gen(input imm_fmt_e f, input logic [31:0] in);
        logic signed [31:0] raw;
        case (f)
            IMM_I:   raw = {{20{in[31]}}, in[31:20]};
            IMM_S:   raw = {{20{in[31]}}, in[31:25], in[11:7]};
            IMM_B:   raw = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            IMM_U:   raw = {in[31:12], 12'b0};
            IMM_J:   raw = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
            default: raw = '0;
        endcase
        return {{(PC_SIZE-32){raw[31]}}, raw};
    endfunction

    logic [6:0]               opcode;
    logic [REG_ADDR_SIZE-1:0] rs1, rs2, rd;
    logic [3:0]               alu_op;
    imm_fmt_e                 fmt;
    logic [CTRL_W-1:0]        ctrl_dec;
    logic                     uses_rs1, uses_rs2;
    logic signed [PC_SIZE-1:0] imm_dec;
    logic [WORD_SIZE-1:0]     rd1, rd2;
    logic                     hazard;

    assign opcode = i_if_id_inst[6:0];
    assign rd     = i_if_id_inst[7 +: REG_ADDR_SIZE];
    assign rs1    = i_if_id_inst[15 +: REG_ADDR_SIZE];
    assign rs2    = i_if_id_inst[20 +: REG_ADDR_SIZE];
    assign alu_op = {i_if_id_inst[30], i_if_id_inst[14:12]};

    always_comb begin
        fmt      = IMM_NONE;
        ctrl_dec = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_dec[CTRL_REG_WR] = 1'b1;
                uses_rs2              = 1'b1;
            end
            OP_LOAD: begin
                fmt                    = IMM_I;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
                ctrl_dec[CTRL_MEM_RD]  = 1'b1;
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
            end
            OP_STORE: begin
                fmt                    = IMM_S;
                ctrl_dec[CTRL_MEM_WR]  = 1'b1;
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
                uses_rs2               = 1'b1;
            end
            OP_BRANCH: begin
                fmt                   = IMM_B;
                ctrl_dec[CTRL_BRANCH] = 1'b1;
                uses_rs2              = 1'b1;
            end
            OP_JAL: begin
                fmt                   = IMM_J;
                ctrl_dec[CTRL_REG_WR] = 1'b1;
                ctrl_dec[CTRL_JUMP]   = 1'b1;
                uses_rs1              = 1'b0;
            end
            OP_JALR: begin
                fmt                    = IMM_I;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
                ctrl_dec[CTRL_JUMP]    = 1'b1;
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
            end
            OP_IMM: begin
                fmt                    = IMM_I;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                fmt                    = IMM_U;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
                uses_rs1               = 1'b0;
            end
            default: ;
        endcase
    end

    assign imm_dec = imm_gen(fmt, i_if_id_inst[31:0]);

    reg_file #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) u_rf (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .wr_en    (i_reg_wr),
        .wr_addr  (i_wr_reg),
        .wr_data  (i_wr_data),
        .rd_addr1 (rs1),
        .rd_addr2 (rs2),
        .rd_data1 (rd1),
        .rd_data2 (rd2)
    );

    // Load in EX whose destination feeds this instruction: data not ready yet.
    assign hazard = o_id_ex_valid & o_id_ex_ctrl[CTRL_MEM_RD] & (o_id_ex_rd != '0) & i_if_id_valid &
                    (((o_id_ex_rd == rs1) & uses_rs1) | ((o_id_ex_rd == rs2) & uses_rs2));

    assign o_if_id_stall = (hazard | i_ex_hold) & ~i_flush;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_id_ex_valid  <= 1'b0;
            o_id_ex_pc     <= '0;
            o_id_ex_rd1    <= '0;
            o_id_ex_rd2    <= '0;
            o_id_ex_imm    <= '0;
            o_id_ex_rs1    <= '0;
            o_id_ex_rs2    <= '0;
            o_id_ex_rd     <= '0;
            o_id_ex_alu_op <= '0;
            o_id_ex_ctrl   <= '0;
        end else if (i_flush) begin
            o_id_ex_valid  <= 1'b0;
            o_id_ex_pc     <= '0;
            o_id_ex_rd1    <= '0;
            o_id_ex_rd2    <= '0;
            o_id_ex_imm    <= '0;
            o_id_ex_rs1    <= '0;
            o_id_ex_rs2    <= '0;
            o_id_ex_rd     <= '0;
            o_id_ex_alu_op <= '0;
            o_id_ex_ctrl   <= '0;
        end else if (i_ex_hold) begin
            o_id_ex_valid  <= o_id_ex_valid;
        end else if (hazard) begin
            o_id_ex_valid  <= 1'b0;
            o_id_ex_ctrl   <= '0;
        end else begin
            o_id_ex_valid  <= i_if_id_valid;
            o_id_ex_pc     <= i_if_id_pc;
            o_id_ex_rd1    <= rd1;
            o_id_ex_rd2    <= rd2;
            o_id_ex_imm    <= imm_dec;
            o_id_ex_rs1    <= rs1;
            o_id_ex_rs2    <= rs2;
            o_id_ex_rd     <= rd;
            o_id_ex_alu_op <= alu_op;
            o_id_ex_ctrl   <= i_if_id_valid ? ctrl_dec : '0;
        end
    end

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Directed bench for inst_dec_pipe with an expected-result queue popped one edge after each issue.
module tb_inst_dec_pipe;

    localparam int WORD_SIZE     = 32;
    localparam int PC_SIZE       = 64;
    localparam int REG_ADDR_SIZE = 5;
`ifdef INST_DEC_WB_BYPASS_EN
    localparam logic [63:0] BYP_RD1 = 64'hDEADBEEF;
`else
    localparam logic [63:0] BYP_RD1 = 64'd68;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     if_valid = 1'b0;
    logic [PC_SIZE-1:0]       if_pc = '0;
    logic [WORD_SIZE-1:0]     if_inst = '0;
    logic                     stall;
    logic                     ex_hold = 1'b0;
    logic                     flush = 1'b0;
    logic                     reg_wr = 1'b0;
    logic [REG_ADDR_SIZE-1:0] wr_reg = '0;
    logic [WORD_SIZE-1:0]     wr_data = '0;
    logic                     id_valid;
    logic [PC_SIZE-1:0]       id_pc;
    logic [WORD_SIZE-1:0]     id_rd1, id_rd2;
    logic [PC_SIZE-1:0]       id_imm;
    logic [REG_ADDR_SIZE-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]               id_alu_op;
    logic [5:0]               id_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    // mode 0: every field, 1: valid/ctrl/imm, 2: valid/ctrl only
    typedef struct {
        string       tag;
        int          mode;
        logic [63:0] valid, pc, rd1, rd2, imm, rs1, rs2, rd, alu_op, ctrl;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    inst_dec_pipe #(
        .WORD_SIZE     (WORD_SIZE),
        .PC_SIZE       (PC_SIZE),
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_if_id_valid  (if_valid),
        .i_if_id_pc     (if_pc),
        .i_if_id_inst   (if_inst),
        .o_if_id_stall  (stall),
        .i_ex_hold      (ex_hold),
        .i_flush        (flush),
        .i_reg_wr       (reg_wr),
        .i_wr_reg       (wr_reg),
        .i_wr_data      (wr_data),
        .o_id_ex_valid  (id_valid),
        .o_id_ex_pc     (id_pc),
        .o_id_ex_rd1    (id_rd1),
        .o_id_ex_rd2    (id_rd2),
        .o_id_ex_imm    (id_imm),
        .o_id_ex_rs1    (id_rs1),
        .o_id_ex_rs2    (id_rs2),
        .o_id_ex_rd     (id_rd),
        .o_id_ex_alu_op (id_alu_op),
        .o_id_ex_ctrl   (id_ctrl)
    );

    function automatic exp_t mk(input string tag, input int mode, input logic [63:0] valid,
                                input logic [63:0] pc, input logic [63:0] rd1, input logic [63:0] rd2,
                                input logic [63:0] imm, input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [63:0] rd, input logic [63:0] alu_op, input logic [63:0] ctrl);
        exp_t e;
        e.tag = tag; e.mode = mode; e.valid = valid; e.pc = pc; e.rd1 = rd1; e.rd2 = rd2;
        e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu_op = alu_op; e.ctrl = ctrl;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [63:0] pc, input logic [31:0] inst, input exp_t e);
        @(negedge clk);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        sb.push_back(e);
    endtask

    task automatic edge_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".valid"}, 64'(id_valid), e.valid);
            chk({e.tag, ".ctrl"}, 64'(id_ctrl), e.ctrl);
            if (e.mode != 2) chk({e.tag, ".imm"}, 64'(id_imm), e.imm);
            if (e.mode == 0) begin
                chk({e.tag, ".pc"}, 64'(id_pc), e.pc);
                chk({e.tag, ".rd1"}, 64'(id_rd1), e.rd1);
                chk({e.tag, ".rd2"}, 64'(id_rd2), e.rd2);
                chk({e.tag, ".rs1"}, 64'(id_rs1), e.rs1);
                chk({e.tag, ".rs2"}, 64'(id_rs2), e.rs2);
                chk({e.tag, ".rd"}, 64'(id_rd), e.rd);
                chk({e.tag, ".alu_op"}, 64'(id_alu_op), e.alu_op);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, 64'(id_valid), 64'd0);
        chk({tag, ".pc"}, 64'(id_pc), 64'd0);
        chk({tag, ".rd1"}, 64'(id_rd1), 64'd0);
        chk({tag, ".rd2"}, 64'(id_rd2), 64'd0);
        chk({tag, ".imm"}, 64'(id_imm), 64'd0);
        chk({tag, ".rs1"}, 64'(id_rs1), 64'd0);
        chk({tag, ".rs2"}, 64'(id_rs2), 64'd0);
        chk({tag, ".rd"}, 64'(id_rd), 64'd0);
        chk({tag, ".alu_op"}, 64'(id_alu_op), 64'd0);
        chk({tag, ".ctrl"}, 64'(id_ctrl), 64'd0);
        chk({tag, ".stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            reg_wr  = 1'b1;
            wr_reg  = 5'(i);
            wr_data = 32'(i + 64);
        end

        issue(1'b0, 64'h0, 32'h0000_0000, mk("x0_write", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        wr_reg  = 5'd0;
        wr_data = 32'd5;
        edge_check();

        issue(1'b1, 64'h100, 32'h002081B3, mk("add_x3", 0, 1, 'h100, 65, 66, 0, 1, 2, 3, 0, 'h20));
        reg_wr = 1'b0;
        edge_check();

        issue(1'b1, 64'h104, 32'hFFF00293,
              mk("addi_x5", 0, 1, 'h104, 0, 95, 64'hFFFF_FFFF_FFFF_FFFF, 0, 31, 5, 8, 'h21));
        edge_check();

        issue(1'b1, 64'h108, 32'h0000A303, mk("lw_x6", 0, 1, 'h108, 65, 0, 0, 1, 0, 6, 2, 'h31));
        edge_check();

        issue(1'b1, 64'h10C, 32'h001303B3, mk("load_use_bubble", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("load_use_stall", 64'(stall), 64'd1);
        edge_check();
        chk("load_use_stall_release", 64'(stall), 64'd0);

        issue(1'b1, 64'h10C, 32'h001303B3, mk("add_x7", 0, 1, 'h10C, 70, 65, 0, 6, 1, 7, 0, 'h20));
        edge_check();

        issue(1'b1, 64'h110, 32'h00020433, mk("wb_same_cycle", 0, 1, 'h110, BYP_RD1, 0, 0, 4, 0, 8, 0, 'h20));
        reg_wr  = 1'b1;
        wr_reg  = 5'd4;
        wr_data = 32'hDEADBEEF;
        edge_check();

        issue(1'b1, 64'h114, 32'h00020433, mk("wb_next_cycle", 0, 1, 'h114, 64'hDEADBEEF, 0, 0, 4, 0, 8, 0, 'h20));
        reg_wr = 1'b0;
        edge_check();

        issue(1'b1, 64'h118, 32'hFE20AE23, mk("sw_imm", 1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 'h09));
        edge_check();
        issue(1'b1, 64'h11C, 32'hFE208CE3, mk("beq_imm", 1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 'h04));
        edge_check();
        issue(1'b1, 64'h120, 32'h800004B7, mk("lui_imm", 1, 1, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 0, 'h21));
        edge_check();
        issue(1'b1, 64'h124, 32'h001000EF, mk("jal_imm", 1, 1, 0, 0, 0, 64'h800, 0, 0, 0, 0, 'h22));
        edge_check();
        issue(1'b1, 64'h128, 32'h0000007F, mk("unknown_op", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_check();
        issue(1'b0, 64'h12C, 32'h002081B3, mk("not_valid", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_check();

        issue(1'b1, 64'h200, 32'h002081B3, mk("pre_hold", 0, 1, 'h200, 65, 66, 0, 1, 2, 3, 0, 'h20));
        edge_check();
        issue(1'b1, 64'h204, 32'hFFF00293, mk("hold", 0, 1, 'h200, 65, 66, 0, 1, 2, 3, 0, 'h20));
        ex_hold = 1'b1;
        #1;
        chk("hold_stall", 64'(stall), 64'd1);
        edge_check();
        issue(1'b1, 64'h204, 32'hFFF00293, mk("flush_over_hold", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall), 64'd0);
        edge_check();

        issue(1'b1, 64'h300, 32'h002081B3, mk("pre_reset", 0, 1, 'h300, 65, 66, 0, 1, 2, 3, 0, 'h20));
        flush   = 1'b0;
        ex_hold = 1'b0;
        edge_check();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");

        issue(1'b1, 64'h304, 32'h002081B3, mk("post_reset", 0, 1, 'h304, 0, 0, 0, 1, 2, 3, 0, 'h20));
        rst_n = 1'b1;
        edge_check();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
